uart_rx_decoder: RTL

- Receives 8N1 serial bytes from the host PC on a single rx line and decodes them into game events.
- Sits directly upstream of uart_controller and drives its proj input, so projectiles fired by the remote side appear in the local game.
- Also exposes the raw received byte and a framing-error flag for debug LEDs.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 28 ++
 rtl/uart_rx_decoder.sv | 114 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: receiver FSM encoding and command bytes exchanged
// between uart_rx_decoder and uart_controller.
package uart_pkg;

  // 100 MHz system clock, 9600 baud
  localparam int DEFAULT_CLKS_PER_BIT = 10417;

  // Command bytes from the remote side; both ends must agree on these
  localparam logic [7:0] CMD_PROJ = 8'h50;  // 'P'
  localparam logic [7:0] CMD_UP   = 8'h55;  // 'U'
  localparam logic [7:0] CMD_DOWN = 8'h44;  // 'D'

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchronizer with a configurable reset value, usable for
// the serial line as well as button inputs.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two back-to-back flops; both load RST_VAL while reset is held low
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_decoder.sv
// 8N1 UART receiver. Samples each bit at its middle, reports the byte with a
// one-cycle rx_valid pulse, flags the projectile command, and pulses
// frame_err on a low stop bit (then waits for the line to return high).
module uart_rx_decoder
  import uart_pkg::*;
#(
  parameter int         CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter logic [7:0] PROJ_CODE    = CMD_PROJ
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       proj,
  output logic       frame_err
);

  localparam int             CW        = $clog2(CLKS_PER_BIT);
  localparam int             HALF      = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  HALF_LAST = CW'(HALF - 1);

  logic            w_rx_s;
  rx_state_e       r_state;
  rx_state_e       w_state_nxt;
  logic [CW-1:0]   r_clk_cnt;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic [7:0]      r_rx_data;
  logic            r_rx_valid;
  logic            r_proj;
  logic            r_frame_err;
  logic            w_bit_tick;
  logic            w_half_tick;
  logic            w_stop_ok;
  logic            w_stop_bad;

  sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
    .i_clk   (clk_in),
    .i_rst_n (rst),
    .i_d     (rx),
    .o_q     (w_rx_s)
  );

  // Next-state logic and stop-bit decode
  always_comb begin
    w_state_nxt = r_state;
    w_bit_tick  = (r_clk_cnt == BIT_LAST);
    w_half_tick = (r_clk_cnt == HALF_LAST);
    w_stop_ok   = 1'b0;
    w_stop_bad  = 1'b0;
    case (r_state)
      ST_IDLE:      if (!w_rx_s) w_state_nxt = ST_START;
      ST_START:     if (w_half_tick) w_state_nxt = w_rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:      if (w_bit_tick && (r_bit_cnt == 3'd7)) w_state_nxt = ST_STOP;
      ST_STOP: begin
        if (w_bit_tick) begin
          w_stop_ok   = w_rx_s;
          w_stop_bad  = !w_rx_s;
          w_state_nxt = w_rx_s ? ST_IDLE : ST_WAIT_HIGH;
        end
      end
      ST_WAIT_HIGH: if (w_rx_s) w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_in) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Bit timing, shift register and registered output pulses
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      r_clk_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_rx_data   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_proj      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      // Counter restarts on every state change and at each bit boundary
      if (w_state_nxt != r_state) begin
        r_clk_cnt <= '0;
      end else if (r_state == ST_START || r_state == ST_DATA || r_state == ST_STOP) begin
        r_clk_cnt <= w_bit_tick ? '0 : r_clk_cnt + 1'b1;
      end else begin
        r_clk_cnt <= '0;
      end

      if (r_state == ST_START) begin
        r_bit_cnt <= '0;
      end else if (r_state == ST_DATA && w_bit_tick) begin
        r_shift   <= {w_rx_s, r_shift[7:1]};  // LSB arrives first
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end

      if (w_stop_ok) r_rx_data <= r_shift;
      r_rx_valid  <= w_stop_ok;
      r_proj      <= w_stop_ok && (r_shift == PROJ_CODE);
      r_frame_err <= w_stop_bad;
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign proj      = r_proj;
  assign frame_err = r_frame_err;

endmodule
